gsim_row_fetch: RTL and testbench

Row-fetch front end for the Gauss-Seidel solver datapath. On start, it streams every 256-bit word of the requested matrices from matrix memory in address order. It runs the memory request/valid handshake, limits outstanding reads with credits, and buffers returned words in a 4-entry FIFO. Each word is presented downstream with a valid/ready handshake, tagged with its matrix and row index. It sits between the matrix memory port and the solver core's row intake.

---
 rtl/gsim_row_fetch.sv | 198 +++++++++++++++++++
 tb/tb_gsim_row_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_row_fetch.sv
// Row-fetch front end: streams matrix words from memory under credit control and
// hands them to the solver through a small tagged FIFO.
module gsim_row_fetch #(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [4:0]   i_matrix_num,
  output logic         o_mem_rreq,
  output logic [9:0]   o_mem_addr,
  input  logic         i_mem_rrdy,
  input  logic [255:0] i_mem_dout,
  input  logic         i_mem_dout_vld,
  output logic         o_row_vld,
  output logic [255:0] o_row_data,
  output logic [3:0]   o_row_mat,
  output logic [4:0]   o_row_idx,
  input  logic         i_row_rdy,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] credit;
  logic [CW-1:0] credit_next;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [9:0]    last_addr;
  logic [9:0]    pop_cnt;
  logic [9:0]    word_total;
  logic [3:0]    ret_mat;
  logic [4:0]    ret_row;
  logic          accept;
  logic          pop;
  logic          push;
  logic          start_ok;
  logic [AW-1:0] wr_pos;

  logic [255:0]     fifo_data [DEPTH];
  logic [3:0]       fifo_mat  [DEPTH];
  logic [4:0]       fifo_idx  [DEPTH];
  logic [DEPTH-1:0] fifo_vld;

  assign o_row_vld  = fifo_vld[0];
  assign o_row_data = fifo_data[0];
  assign o_row_mat  = fifo_mat[0];
  assign o_row_idx  = fifo_idx[0];

  // Words per run is 17*N, built as 16*N + N so no multiplier is needed.
  always_comb begin
    accept     = o_mem_rreq & i_mem_rrdy;
    pop        = fifo_vld[0] & i_row_rdy;
    push       = i_mem_dout_vld & (inflight != '0);
    start_ok   = (state == IDLE) & i_start;
    word_total = {1'b0, i_matrix_num, 4'd0} + {5'd0, i_matrix_num};
    credit_next = credit;
    if (accept & ~pop) begin
      credit_next = credit - CW'(1);
    end else if (pop & ~accept) begin
      credit_next = credit + CW'(1);
    end
    wr_pos = pop ? AW'(fifo_cnt - CW'(1)) : AW'(fifo_cnt);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      o_mem_rreq <= 1'b0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      last_addr  <= '0;
      pop_cnt    <= '0;
    end else begin
      o_done <= 1'b0;
      if (pop) begin
        pop_cnt <= pop_cnt + 10'd1;
      end
      case (state)
        IDLE: begin
          o_mem_rreq <= 1'b0;
          if (i_start) begin
            o_mem_addr <= '0;
            pop_cnt    <= '0;
            last_addr  <= word_total - 10'd1;
            if (i_matrix_num == 5'd0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state  <= FETCH;
              o_busy <= 1'b1;
            end
          end
        end
        // Request line is recomputed from post-edge credit, so it never rises with zero credit.
        FETCH: begin
          if (accept) begin
            o_mem_addr <= o_mem_addr + 10'd1;
            if (o_mem_addr == last_addr) begin
              state      <= DRAIN;
              o_mem_rreq <= 1'b0;
            end else begin
              o_mem_rreq <= (credit_next != '0);
            end
          end else begin
            o_mem_rreq <= (credit_next != '0);
          end
        end
        DRAIN: begin
          o_mem_rreq <= 1'b0;
          if (pop && (pop_cnt == last_addr)) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        DONE: begin
          o_mem_rreq <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          o_mem_rreq <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      credit   <= CW'(DEPTH);
      inflight <= '0;
      ret_mat  <= '0;
      ret_row  <= '0;
    end else begin
      credit <= credit_next;
      if (accept & ~push) begin
        inflight <= inflight + CW'(1);
      end else if (push & ~accept) begin
        inflight <= inflight - CW'(1);
      end
      if (start_ok) begin
        ret_mat <= '0;
        ret_row <= '0;
      end else if (push) begin
        if (ret_row == 5'd16) begin
          ret_row <= '0;
          ret_mat <= ret_mat + 4'd1;
        end else begin
          ret_row <= ret_row + 5'd1;
        end
      end
    end
  end

  // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[AW'(i)] <= '0;
        fifo_mat[AW'(i)]  <= '0;
        fifo_idx[AW'(i)]  <= '0;
      end
      fifo_vld <= '0;
      fifo_cnt <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_data[AW'(i)] <= fifo_data[AW'(i + 1)];
          fifo_mat[AW'(i)]  <= fifo_mat[AW'(i + 1)];
          fifo_idx[AW'(i)]  <= fifo_idx[AW'(i + 1)];
        end
        fifo_data[DEPTH-1] <= '0;
        fifo_mat[DEPTH-1]  <= '0;
        fifo_idx[DEPTH-1]  <= '0;
        fifo_vld <= {1'b0, fifo_vld[DEPTH-1:1]};
      end
      if (push) begin
        fifo_data[wr_pos] <= i_mem_dout;
        fifo_mat[wr_pos]  <= ret_mat;
        fifo_idx[wr_pos]  <= ret_row;
        fifo_vld[wr_pos]  <= 1'b1;
      end
      if (push & ~pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop & ~push) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gsim_row_fetch.sv
// Randomized bench for gsim_row_fetch: a memory model with in-order variable latency
// feeds the DUT, and the expected word stream is derived from word index arithmetic.
module tb_gsim_row_fetch;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [4:0]   i_matrix_num;
  logic         o_mem_rreq;
  logic [9:0]   o_mem_addr;
  logic         i_mem_rrdy;
  logic [255:0] i_mem_dout;
  logic         i_mem_dout_vld;
  logic         o_row_vld;
  logic [255:0] o_row_data;
  logic [3:0]   o_row_mat;
  logic [4:0]   o_row_idx;
  logic         i_row_rdy;
  logic         o_busy;
  logic         o_done;

  gsim_row_fetch #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_matrix_num(i_matrix_num),
    .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr), .i_mem_rrdy(i_mem_rrdy),
    .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_row_vld(o_row_vld), .o_row_data(o_row_data), .o_row_mat(o_row_mat),
    .o_row_idx(o_row_idx), .i_row_rdy(i_row_rdy), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int total, acc_cnt, pop_cnt, push_cnt;
  int pend_addr[$];
  int pend_due[$];
  int rrdy_pct, rdy_pct, lat_min, lat_max;
  int stall_addr, stall_left, stall_seen;
  bit force_rdy0, job_active, drive_start, prev_stall;
  logic [4:0] drive_n;
  logic [9:0] prev_addr;
  int start_cyc, first_rreq_cyc, first_acc_cyc, last_acc_cyc, final_pop_cyc;
  int done_cnt, done_cyc, last_acc_addr;
  logic [3:0] last_mat;
  logic [4:0] last_idx;

  // Memory contents are a fixed function of the word address.
  function automatic logic [255:0] mem_word(input int a);
    logic [255:0] w;
    for (int j = 0; j < 8; j++)
      w[j*32 +: 32] = (a * 32'h0100_0193) ^ (j * 32'h85EB_CA6B) ^ 32'hA5A5_0000;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: compare outputs against the model, then drive the next inputs.
  task automatic applyStimulus();
    int  lat;
    bit  rr, rd;
    @(negedge clk);
    if (job_active) begin
      if (total > 0) begin
        checkOutput("busy", o_busy, (cyc > start_cyc) && (final_pop_cyc < 0 || cyc <= final_pop_cyc));
        checkOutput("done", o_done, (final_pop_cyc >= 0) && (cyc == final_pop_cyc + 1));
      end
      checkOutput("row_vld", o_row_vld, push_cnt > pop_cnt);
      if (o_row_vld && push_cnt > pop_cnt) begin
        checkOutput("row_data", o_row_data, mem_word(pop_cnt));
        checkOutput("row_mat", o_row_mat, pop_cnt / 17);
        checkOutput("row_idx", o_row_idx, pop_cnt % 17);
      end
      if (o_mem_rreq) begin
        checkOutput("rreq_allowed", (acc_cnt < total) && (acc_cnt - pop_cnt < DEPTH), 1'b1);
        if (first_rreq_cyc < 0) first_rreq_cyc = cyc;
      end
      if (prev_stall) begin
        checkOutput("stall_rreq_hold", o_mem_rreq, 1'b1);
        checkOutput("stall_addr_hold", o_mem_addr, prev_addr);
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    i_start      = drive_start;
    i_matrix_num = drive_n;
    drive_start  = 1'b0;
    if (stall_left > 0 && o_mem_rreq && o_mem_addr == 10'(stall_addr)) begin
      rr = 1'b0;
      stall_left--;
      stall_seen++;
    end else begin
      rr = ($urandom_range(99) < rrdy_pct);
    end
    rd = force_rdy0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
    i_mem_rrdy = rr;
    i_row_rdy  = rd;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      push_cnt++;
    end else begin
      i_mem_dout_vld = 1'b0;
      i_mem_dout     = {8{$urandom()}};
    end
    if (o_mem_rreq && rr) begin
      checkOutput("req_addr", o_mem_addr, acc_cnt);
      lat = $urandom_range(lat_max, lat_min);
      pend_addr.push_back(int'(o_mem_addr));
      pend_due.push_back(cyc + lat);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc  = cyc;
      last_acc_addr = int'(o_mem_addr);
      acc_cnt++;
    end
    if (o_row_vld && rd) begin
      last_mat = o_row_mat;
      last_idx = o_row_idx;
      pop_cnt++;
      if (pop_cnt == total) final_pop_cyc = cyc;
    end
    prev_stall = o_mem_rreq && !rr;
    prev_addr  = o_mem_addr;
    cyc++;
  endtask

  task automatic run_job(input int n, input int budget, input int bp_cycles,
                         input int busy_start_at, input logic [4:0] busy_n, input int abort_pop);
    int k;
    total = 17 * n;
    acc_cnt = 0; pop_cnt = 0; push_cnt = 0;
    first_rreq_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; final_pop_cyc = -1;
    done_cnt = 0; done_cyc = -1; last_acc_addr = -1; stall_seen = 0; prev_stall = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    job_active  = 1'b1;
    force_rdy0  = (bp_cycles > 0);
    drive_start = 1'b1;
    drive_n     = 5'(n);
    start_cyc   = cyc;
    applyStimulus();
    k = 1;
    while (!(final_pop_cyc >= 0 && cyc > final_pop_cyc + 3) && !(total == 0 && cyc > start_cyc + 4) &&
           !(abort_pop > 0 && pop_cnt >= abort_pop) && k < budget) begin
      if (bp_cycles > 0 && k == bp_cycles) begin
        checkOutput("bp_accepts", acc_cnt, 4);
        checkOutput("bp_last_addr", last_acc_addr, 3);
        checkOutput("bp_rreq_low", o_mem_rreq, 1'b0);
        force_rdy0 = 1'b0;
      end
      if (k == busy_start_at) begin
        drive_start = 1'b1;
        drive_n     = busy_n;
      end
      applyStimulus();
      k++;
    end
    if (k >= budget) begin
      tests++;
      fails++;
      $display("[TB] FAIL job_timeout: got %0d cycles without completion, required under %0d", k, budget);
    end
  endtask

  task automatic check_single(input string tag);
    checkOutput({tag, "_first_req_latency"}, first_rreq_cyc - start_cyc, 2);
    checkOutput({tag, "_burst_span"}, last_acc_cyc - first_acc_cyc, 16);
    checkOutput({tag, "_req_count"}, acc_cnt, 17);
    checkOutput({tag, "_pop_count"}, pop_cnt, 17);
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_last_tag"}, {last_mat, last_idx}, {4'd0, 5'd16});
  endtask

  task automatic set_knobs(input int rr, input int rd, input int lmin, input int lmax);
    rrdy_pct = rr; rdy_pct = rd; lat_min = lmin; lat_max = lmax;
    stall_addr = -1; stall_left = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_matrix_num = '0; i_mem_rrdy = 1'b0;
    i_mem_dout = '0; i_mem_dout_vld = 1'b0; i_row_rdy = 1'b0;
    drive_start = 1'b0; drive_n = '0; job_active = 1'b0; force_rdy0 = 1'b0;
    set_knobs(100, 100, 1, 1);
    repeat (2) @(negedge clk);
    checkOutput("reset_rreq", o_mem_rreq, 1'b0);
    checkOutput("reset_addr", o_mem_addr, 10'd0);
    checkOutput("reset_row_vld", o_row_vld, 1'b0);
    checkOutput("reset_row_data", o_row_data, 256'd0);
    checkOutput("reset_tags", {o_row_mat, o_row_idx}, 9'd0);
    checkOutput("reset_busy_done", {o_busy, o_done}, 2'b00);
    i_reset = 1'b1;

    $display("[TB] single matrix, full-rate memory and sink");
    set_knobs(100, 100, 1, 1);
    run_job(1, 200, 0, -1, 5'd0, 0);
    check_single("s1");

    $display("[TB] backpressure from the row sink");
    run_job(1, 300, 12, -1, 5'd0, 0);
    checkOutput("bp_req_count", acc_cnt, 17);
    checkOutput("bp_done_pulses", done_cnt, 1);

    $display("[TB] memory stall at address 7");
    set_knobs(100, 100, 1, 1);
    stall_addr = 7; stall_left = 5;
    run_job(1, 200, 0, -1, 5'd0, 0);
    checkOutput("stall_cycles", stall_seen, 5);
    checkOutput("stall_req_count", acc_cnt, 17);
    checkOutput("stall_done_pulses", done_cnt, 1);

    $display("[TB] sixteen matrices, random handshakes and latency");
    set_knobs(70, 70, 1, 3);
    run_job(16, 4000, 0, 50, 5'd0, 0);
    checkOutput("full_req_count", acc_cnt, 272);
    checkOutput("full_pop_count", pop_cnt, 272);
    checkOutput("full_last_addr", last_acc_addr, 271);
    checkOutput("full_last_tag", {last_mat, last_idx}, {4'd15, 5'd16});
    checkOutput("full_done_pulses", done_cnt, 1);

    $display("[TB] zero-matrix start with a start during completion");
    set_knobs(100, 100, 1, 1);
    run_job(0, 10, 0, 1, 5'd1, 0);
    checkOutput("n0_done_pulses", done_cnt, 1);
    checkOutput("n0_done_delay_ok", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1'b1);
    checkOutput("n0_no_rreq", first_rreq_cyc < 0, 1'b1);

    $display("[TB] reset in the middle of a run");
    set_knobs(80, 80, 1, 3);
    run_job(16, 2000, 0, -1, 5'd0, 40);
    checkOutput("abort_point", pop_cnt >= 40, 1'b1);
    job_active = 1'b0;
    i_reset = 1'b0;
    i_start = 1'b0; i_mem_rrdy = 1'b0; i_row_rdy = 1'b0; i_mem_dout_vld = 1'b0;
    #1;
    checkOutput("midreset_rreq", o_mem_rreq, 1'b0);
    checkOutput("midreset_addr", o_mem_addr, 10'd0);
    checkOutput("midreset_row_vld", o_row_vld, 1'b0);
    checkOutput("midreset_row_data", o_row_data, 256'd0);
    checkOutput("midreset_tags", {o_row_mat, o_row_idx}, 9'd0);
    checkOutput("midreset_busy_done", {o_busy, o_done}, 2'b00);
    pend_addr.delete();
    pend_due.delete();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_mem_dout_vld = 1'b1;
    i_mem_dout     = {8{$urandom()}};
    @(negedge clk);
    i_mem_dout_vld = 1'b0;
    checkOutput("stray_vld_ignored", o_row_vld, 1'b0);
    @(negedge clk);
    checkOutput("stray_vld_still_empty", o_row_vld, 1'b0);
    checkOutput("post_reset_idle", {o_mem_rreq, o_busy, o_done}, 3'b000);

    $display("[TB] fresh single-matrix run after reset");
    set_knobs(100, 100, 1, 1);
    run_job(1, 200, 0, -1, 5'd0, 0);
    check_single("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
